// File: rtl/sbox_builder_if.sv
// Valid/ready stream carrying chaotic words into the S-box builder.
interface sbox_builder_if #(
  parameter int IN_W = 23
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sbox_builder.sv
// Builds a bijective 2^SYM_W-entry S-box (and its inverse) from first occurrences
// of folded chaotic words, completing it in ascending order if the stream stalls.
module sbox_builder #(
  parameter int SYM_W     = 8,
  parameter int IN_W      = 23,
  parameter int MAX_TRIES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  sbox_builder_if.slave    in_s,
  output logic             busy,
  output logic             done,
  output logic             fill_used,
  output logic [SYM_W:0]   count,
  input  logic [SYM_W-1:0] lk_addr,
  input  logic             lk_inv,
  output logic [SYM_W-1:0] lk_data
);

  localparam int N       = 1 << SYM_W;
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, COLLECT, FILL, DONE} state_t;

  state_t             state, state_n;
  logic [N-1:0]       seen;
  logic [TRIES_W-1:0] tries, tries_n;
  logic [SYM_W-1:0]   p;
  logic [SYM_W:0]     count_n;
  logic [SYM_W-1:0]   sym, wr_sym;
  logic               accept, wr_en;

  logic [SYM_W-1:0]   tbl [N];
  logic [SYM_W-1:0]   inv [N];

  assign sym = in_s.in_data[SYM_W-1:0] ^ in_s.in_data[2*SYM_W-1:SYM_W];

  generate
    if (IN_W > 2*SYM_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^in_s.in_data[IN_W-1:2*SYM_W];
    end
  endgenerate

  assign in_s.in_ready = (state == COLLECT);
  assign busy          = (state == CLEAR) || (state == COLLECT) || (state == FILL);
  assign done          = (state == DONE);

  // COLLECT and FILL share one write port; FILL feeds the scan pointer instead of the fold.
  always_comb begin
    accept  = (state == COLLECT) && in_s.in_valid;
    wr_sym  = (state == FILL) ? p : sym;
    wr_en   = (accept && !seen[sym]) || ((state == FILL) && !seen[p]);
    count_n = count + (SYM_W+1)'(wr_en);
    tries_n = tries + TRIES_W'(accept);
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = CLEAR;
      CLEAR:      state_n = COLLECT;
      COLLECT: begin
        if (count_n == (SYM_W+1)'(N))
          state_n = DONE;
        else if (tries_n == TRIES_W'(MAX_TRIES))
          state_n = FILL;
      end
      FILL:       if (count_n == (SYM_W+1)'(N)) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      seen      <= '0;
      count     <= '0;
      tries     <= '0;
      p         <= '0;
      fill_used <= 1'b0;
      lk_data   <= '0;
    end else begin
      state <= state_n;
      if (state == CLEAR) begin
        seen      <= '0;
        count     <= '0;
        tries     <= '0;
        p         <= '0;
        fill_used <= 1'b0;
      end else begin
        if (wr_en) seen[wr_sym] <= 1'b1;
        count <= count_n;
        if (accept) tries <= tries_n;
        if (state == FILL) p <= p + SYM_W'(1);
        if ((state == COLLECT) && (state_n == FILL)) begin
          fill_used <= 1'b1;
          p         <= '0;
        end
      end
      lk_data <= done ? (lk_inv ? inv[lk_addr] : tbl[lk_addr]) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl[count[SYM_W-1:0]] <= wr_sym;
      inv[wr_sym]           <= count[SYM_W-1:0];
    end
  end

endmodule

// File: tb/tb_sbox_builder.sv
// Randomised directed bench for sbox_builder against an order-of-arrival table model.
module tb_sbox_builder;
  localparam int SYM_W     = 8;
  localparam int IN_W      = 23;
  localparam int MAX_TRIES = 300;
  localparam int N         = 256;

  logic             clk = 0;
  logic             rst = 0;
  logic             start = 0;
  logic             busy, done, fill_used;
  logic [SYM_W:0]   count;
  logic [SYM_W-1:0] lk_addr = '0;
  logic             lk_inv = 0;
  logic [SYM_W-1:0] lk_data;

  sbox_builder_if #(.IN_W(IN_W)) bus ();

  sbox_builder #(.SYM_W(SYM_W), .IN_W(IN_W), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .rst(rst), .start(start), .in_s(bus.slave),
    .busy(busy), .done(done), .fill_used(fill_used), .count(count),
    .lk_addr(lk_addr), .lk_inv(lk_inv), .lk_data(lk_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: list of symbols in order of first arrival.
  int m_tbl [N];
  int m_inv [N];
  bit m_seen [N];
  int m_cnt, m_tries;
  bit m_collect, m_filling, m_done, m_fill_used;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_seen[i] = 0;
    m_cnt = 0; m_tries = 0;
    m_collect = 0; m_filling = 0; m_done = 0; m_fill_used = 0;
  endfunction

  function automatic void m_accept(input int s);
    m_tries++;
    if (!m_seen[s]) begin
      m_tbl[m_cnt] = s;
      m_inv[s]     = m_cnt;
      m_seen[s]    = 1;
      m_cnt++;
    end
    if (m_cnt == N) begin
      m_collect = 0; m_done = 1;
    end else if (m_tries == MAX_TRIES) begin
      m_collect = 0; m_filling = 1; m_fill_used = 1;
    end
  endfunction

  // Appends missing symbols ascending; returns cycles the scan needs (largest missing + 1).
  function automatic int m_fill();
    int last = 0;
    for (int s = 0; s < N; s++)
      if (!m_seen[s]) begin
        m_tbl[m_cnt] = s; m_inv[s] = m_cnt; m_seen[s] = 1; m_cnt++;
        last = s + 1;
      end
    return last;
  endfunction

  task automatic feed(input logic [7:0] s, input bit v);
    logic [7:0] hi;
    bit acc, was_done;
    hi = 8'($urandom);
    bus.in_data  = {7'($urandom), hi, hi ^ s};
    bus.in_valid = v;
    #1;
    check("in_ready", bus.in_ready, m_collect);
    acc      = v && m_collect;
    was_done = m_done;
    @(posedge clk); #1;
    if (acc) m_accept(s);
    check("count", count, m_cnt);
    check("busy", busy, m_collect || m_filling);
    check("done", done, m_done);
    if (!was_done) check("lk_zero", lk_data, 0);
  endtask

  task automatic do_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    m_reset();
    check("clr_busy", busy, 1);
    check("clr_done", done, 0);
    check("clr_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    m_collect = 1;
    check("col_ready", bus.in_ready, 1);
    check("col_count", count, 0);
    check("col_fill_used", fill_used, 0);
  endtask

  task automatic finish_build();
    int exp_n, n;
    if (m_filling) begin
      exp_n = m_fill();
      n = 0;
      bus.in_valid = 1;
      while (!done && n < 2*N) begin
        #1;
        check("fill_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        n++;
      end
      m_filling = 0; m_done = 1;
      check("fill_cycles", n, exp_n);
    end
    bus.in_valid = 0;
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_count", count, N);
    check("end_fill_used", fill_used, m_fill_used);
  endtask

  task automatic lk_check();
    for (int k = 0; k < N; k++) begin
      lk_addr = 8'(k); lk_inv = 0;
      @(posedge clk); #1;
      check("lk_fwd", lk_data, m_tbl[k]);
      lk_inv = 1;
      @(posedge clk); #1;
      check("lk_inv", lk_data, m_inv[k]);
    end
  endtask

  initial begin
    bus.in_valid = 0;
    bus.in_data  = '0;
    m_reset();
    rst = 1; #12; rst = 0; #1;
    check("rst_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fill_used", fill_used, 0);
    check("rst_count", count, 0);
    check("rst_lk", lk_data, 0);

    // In-order stream: identity table, no fill.
    @(posedge clk); #1;
    do_start();
    for (int i = 0; i < N; i++) feed(8'(i), 1);
    bus.in_valid = 0;
    finish_build();
    lk_check();

    // Duplicates discarded: 0x5A three times then the rest.
    do_start();
    for (int i = 0; i < 3; i++) feed(8'h5A, 1);
    check("dup_count", count, 1);
    for (int i = 0; i < N; i++) if (i != 8'h5A) feed(8'(i), 1);
    check("dup_tries", dut.tries, 258);
    check("dup_first", m_tbl[0], 8'h5A);
    finish_build();
    lk_check();

    // Starved stream: only 0x10..0x1F, forces fallback fill.
    do_start();
    for (int i = 0; m_collect && i < 1000; i++) feed(8'(8'h10 + i % 16), 1);
    check("starve_fill_state", m_filling, 1);
    finish_build();
    lk_check();

    // Async reset mid-collect at count=100, then start while busy.
    do_start();
    for (int i = 0; i < 100; i++) feed(8'(i * 7), 1);
    check("pre_rst_count", count, 100);
    #2 rst = 1; #1;
    check("arst_busy", busy, 0);
    check("arst_count", count, 0);
    check("arst_done", done, 0);
    check("arst_ready", bus.in_ready, 0);
    @(posedge clk); #1 rst = 0;
    m_reset();
    feed(8'h33, 1);
    do_start();
    for (int i = 0; i < 10; i++) feed(8'(i), 1);
    start = 1;
    feed(8'h99, 1);
    start = 0;
    check("busy_start_ready", bus.in_ready, 1);

    // Random stream with random in_valid.
    for (int i = 0; m_collect && i < 2000; i++) feed(8'($urandom), 1'($urandom));
    finish_build();
    lk_check();

    // Restart from DONE with a fresh random build.
    do_start();
    for (int i = 0; m_collect && i < 2000; i++) feed(8'($urandom), 1'($urandom));
    finish_build();
    lk_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sbox_builder.md
Name: sbox_builder

Overview:
- Parametrised successor to the chaotic S-box generation chain.
- Consumes a stream of chaotic words (e.g. extracted/mixed mantissas) over a valid/ready handshake and folds each word to a SYM_W-bit symbol.
- Keeps only first occurrences, building a bijective 2^SYM_W-entry S-box and its inverse.
- If the stream fails to produce all symbols within MAX_TRIES accepted words, deterministically completes the table; then serves forward/inverse lookups to the cipher datapath.

Parameters:
- SYM_W, 8, symbol width; table depth N = 2^SYM_W.
- IN_W, 23, input word width; must satisfy IN_W >= 2*SYM_W.
- MAX_TRIES, 4096, accepted-word budget before fallback fill; must be >= N.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a new build from IDLE or DONE.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  IN_W  chaotic word.
- busy  out  1  build in progress (CLEAR, COLLECT or FILL).
- done  out  1  table complete; held until next start or reset.
- fill_used  out  1  FILL phase ran during the last build.
- count  out  SYM_W+1  entries written so far, 0..N.
- lk_addr  in  SYM_W  lookup index.
- lk_inv  in  1  0 = forward (table[lk_addr]), 1 = inverse (inv[lk_addr]).
- lk_data  out  SYM_W  lookup result, registered.

Behaviour:
- Reset (asynchronous): state IDLE.
  - in_ready=0, busy=0, done=0, fill_used=0, count=0, lk_data=0.
  - seen bitmap cleared; tries=0. Table contents need not be reset.
- Symbol fold: sym = in_data[SYM_W-1:0] XOR in_data[2*SYM_W-1:SYM_W]; upper bits ignored.
- States: IDLE, CLEAR, COLLECT, FILL, DONE.
  - IDLE/DONE, start=1: go to CLEAR.
  - CLEAR (1 cycle): clear seen, count, tries and fill_used; done=0; then COLLECT.
  - COLLECT:
    - in_ready=1; a word is accepted when in_valid && in_ready; each accepted word increments tries.
    - If seen[sym]=0: table[count]=sym, inv[sym]=count, seen[sym]=1, count++.
    - If seen[sym]=1: discard the word; only tries increments.
    - When count reaches N: go to DONE next cycle, even if this is the same cycle tries reaches MAX_TRIES. Completion has priority.
    - Else, when tries reaches MAX_TRIES: go to FILL with scan pointer p=0.
  - FILL:
    - in_ready=0; fill_used=1.
    - Each cycle examine candidate p. If !seen[p], write it exactly as in COLLECT. Then p++.
    - When count reaches N: go to DONE. Cost is at most N cycles.
    - Result: missing symbols are appended in ascending order.
  - DONE: done=1, busy=0, in_ready=0.
- start is ignored while busy.
- in_ready is combinational from state only; it never depends on in_valid.
- Lookup:
  - lk_data <= (lk_inv ? inv[lk_addr] : table[lk_addr]) on every clock while done=1; 1-cycle latency.
  - While done=0, lk_data is held at 0.
- Invariants:
  - count never exceeds N and never decrements except in CLEAR.
  - Once done=1, table and inv are exact inverses.
- Reset mid-build: abort immediately to IDLE with all reset values; a new start is required.
- in_valid while not in COLLECT: no acceptance and no side effects.

Test Plan:
- SYM_W=8: feed words whose fold gives 0,1,...,255 in order, in_valid held high -> in_ready high 256 cycles; done rises exactly 1 cycle after the 256th acceptance; count=256; fill_used=0; table[i]=i.
- Feed symbol 0x5A three times, then the remaining 255 values -> duplicates discarded, count stays 1 across the repeats, tries=258 at completion, table[0]=0x5A.
- MAX_TRIES=300: send only symbols 0x10..0x1F repeatedly -> after the 300th acceptance the block enters FILL; final table[0..15]=0x10..0x1F, table[16]=0x00, table[255]=0xFF; fill_used=1.
- After done: lk_addr=0x37, lk_inv=0 then 1 -> lk_data equals table[0x37] one cycle later, then the index whose entry is 0x37; inv[table[k]]==k for all k.
- Assert rst at count=100 mid-COLLECT -> busy=0, count=0, done=0 on the same edge (async). start during busy -> no state change. start in DONE -> done drops next cycle and a rebuild runs.
- Toggle in_valid randomly (50%) with a random stream -> acceptances only on cycles with in_valid && in_ready; count equals the number of distinct symbols accepted.
